// File: rtl/dkong_prog_pkg.sv
// Shared constants and state encodings for the dkong program-ROM loader.
//   CMD_WRITE / CMD_READ : host command bytes
//   RSP_ACK / RSP_NAK    : response bytes sent back on the serial link
//   prog_state_e         : command FSM states
//   rx_state_e           : UART receiver states
package dkong_prog_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD_AH,
    ST_CMD_AL,
    ST_CMD_LH,
    ST_CMD_LL,
    ST_DATA,
    ST_WRITE,
    ST_RESP,
    ST_RD_EN,
    ST_RD_CAP,
    ST_RD_TX
  } prog_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/prog_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, falling-edge start detect re-checked
// at mid-bit, data sampled at bit centres LSB first.
//   clk_i, rst_ni : clock, async active-low reset
//   rx_i          : serial input, idle high
//   rx_data_o     : last received byte
//   rx_valid_o    : one-cycle pulse, good stop bit
//   frame_err_o   : one-cycle pulse, stop bit sampled low (byte dropped)
module prog_uart_rx
  import dkong_prog_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state_q, state_d;
  logic [2:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          rx_s, rx_prev;

  // sync_q[1] is the synchronized line; sync_q[2] its previous value for edge detect
  assign rx_s    = sync_q[1];
  assign rx_prev = sync_q[2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RX_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], rx_i};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d  = '0;
          data_d = {rx_s, data_q[7:1]};
          bit_d  = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          valid_d = rx_s;
          ferr_d  = !rx_s;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/dkong_prog_loader.sv
// Serial program-ROM loader for dkong_system. Accepts 'W' ADDR_HI ADDR_LO
// LEN_HI LEN_LO DATA[LEN] over 8N1 UART, writes the ROM port, answers ACK+sum
// or NAK, and holds the system in reset while a command is active.
// Build option: PROGLOAD_READBACK_EN adds 'R' ADDR_HI ADDR_LO LEN_HI LEN_LO.
//   masterclk, rst_n     : clock, async active-low reset
//   ser_in / ser_out     : UART RX / TX, idle high
//   prog_en/we/addr/din  : ROM port strobe, write enable, address, write data
//   prog_dout            : ROM read data, valid one cycle after prog_en
//   sys_hold             : 1 = keep dkong_system in reset
//   busy                 : 1 = FSM not idle
module dkong_prog_loader
  import dkong_prog_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 2**20
) (
  input  logic        masterclk,
  input  logic        rst_n,
  input  logic        ser_in,
  output logic        ser_out,
  output logic        prog_en,
  output logic        prog_we,
  output logic [13:0] prog_addr,
  output logic [7:0]  prog_din,
  input  logic [7:0]  prog_dout,
  output logic        sys_hold,
  output logic        busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CLKS);

  logic [7:0] rx_data;
  logic       rx_valid, frame_err;

  prog_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i      (masterclk),
    .rst_ni     (rst_n),
    .rx_i       (ser_in),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .frame_err_o(frame_err)
  );

  // TX shifter: idles all-ones so ser_out comes straight from a flop
  logic [9:0]    tx_shift_q;
  logic [3:0]    tx_bits_q;
  logic [CW-1:0] tx_cnt_q;
  logic          tx_busy_q, tx_load;
  logic [7:0]    tx_byte;

  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '1;
      tx_bits_q  <= '0;
      tx_cnt_q   <= '0;
      tx_busy_q  <= 1'b0;
    end else if (tx_load) begin
      tx_shift_q <= {1'b1, tx_byte, 1'b0};
      tx_bits_q  <= '0;
      tx_cnt_q   <= '0;
      tx_busy_q  <= 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == FULL) begin
        tx_cnt_q   <= '0;
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        if (tx_bits_q == 4'd9) tx_busy_q <= 1'b0;
        else                   tx_bits_q <= tx_bits_q + 1'b1;
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  assign ser_out = tx_shift_q[0];

  prog_state_e   state_q, state_d;
  logic [13:0]   addr_q, addr_d;
  logic [7:0]    din_q, din_d, sum_q, sum_d;
  logic [15:0]   len_q, len_d, resp_q, resp_d;
  logic [1:0]    left_q, left_d;
  logic          hold_q, hold_d;
  logic          is_rd_q, is_rd_d;
  logic [TW-1:0] to_cnt_q;
  logic          timeout, to_active;

  assign to_active = state_q inside {ST_CMD_AH, ST_CMD_AL, ST_CMD_LH, ST_CMD_LL,
                                     ST_DATA, ST_WRITE};
  assign timeout   = (to_cnt_q == TO_MAX);

  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      din_q    <= '0;
      sum_q    <= '0;
      len_q    <= '0;
      resp_q   <= '0;
      left_q   <= '0;
      hold_q   <= 1'b0;
      is_rd_q  <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      resp_q  <= resp_d;
      left_q  <= left_d;
      hold_q  <= hold_d;
      is_rd_q <= is_rd_d;
      if (!to_active || rx_valid) to_cnt_q <= '0;
      else if (!timeout)          to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    sum_d   = sum_q;
    len_d   = len_q;
    resp_d  = resp_q;
    left_d  = left_q;
    hold_d  = hold_q;
    is_rd_d = is_rd_q;
    tx_load = 1'b0;
    tx_byte = resp_q[7:0];
    prog_en = 1'b0;
    prog_we = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          sum_d = '0;
          if (rx_data == CMD_WRITE) begin
            state_d = ST_CMD_AH;
            hold_d  = 1'b1;
            is_rd_d = 1'b0;
`ifdef PROGLOAD_READBACK_EN
          end else if (rx_data == CMD_READ) begin
            state_d = ST_CMD_AH;
            hold_d  = 1'b1;
            is_rd_d = 1'b1;
`endif
          end else begin
            state_d = ST_RESP;
            resp_d  = {8'h00, RSP_NAK};
            left_d  = 2'd1;
          end
        end
      end
      ST_CMD_AH, ST_CMD_AL, ST_CMD_LH, ST_CMD_LL, ST_DATA: begin
        if (frame_err || timeout) begin
          state_d = ST_RESP;
          resp_d  = {8'h00, RSP_NAK};
          left_d  = 2'd1;
        end else if (rx_valid) begin
          unique case (state_q)
            ST_CMD_AH: begin
              addr_d[13:8] = rx_data[5:0];
              state_d      = ST_CMD_AL;
            end
            ST_CMD_AL: begin
              addr_d[7:0] = rx_data;
              state_d     = ST_CMD_LH;
            end
            ST_CMD_LH: begin
              len_d[15:8] = rx_data;
              state_d     = ST_CMD_LL;
            end
            ST_CMD_LL: begin
              len_d[7:0] = rx_data;
              if ({len_q[15:8], rx_data} == 16'h0000) begin
                state_d = ST_RESP;
                resp_d  = {sum_q, RSP_ACK};
                left_d  = 2'd2;
              end else begin
                state_d = is_rd_q ? ST_RD_EN : ST_DATA;
              end
            end
            default: begin
              din_d   = rx_data;
              state_d = ST_WRITE;
            end
          endcase
        end
      end
      ST_WRITE: begin
        prog_en = 1'b1;
        prog_we = 1'b1;
        addr_d  = addr_q + 14'd1;
        len_d   = len_q - 16'd1;
        sum_d   = sum_q + din_q;
        if (len_q == 16'd1) begin
          state_d = ST_RESP;
          resp_d  = {sum_q + din_q, RSP_ACK};
          left_d  = 2'd2;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        // resp_q holds the pending bytes low-first; left_q counts them
        if (!tx_busy_q) begin
          if (left_q != 2'd0) begin
            tx_load = 1'b1;
            resp_d  = {8'h00, resp_q[15:8]};
            left_d  = left_q - 2'd1;
          end else begin
            state_d = ST_IDLE;
            hold_d  = 1'b0;
          end
        end
      end
`ifdef PROGLOAD_READBACK_EN
      ST_RD_EN: begin
        prog_en = 1'b1;
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        tx_load = 1'b1;
        tx_byte = prog_dout;
        sum_d   = sum_q + prog_dout;
        addr_d  = addr_q + 14'd1;
        len_d   = len_q - 16'd1;
        state_d = ST_RD_TX;
      end
      ST_RD_TX: begin
        if (!tx_busy_q) begin
          if (len_q == 16'd0) begin
            state_d = ST_RESP;
            resp_d  = {sum_q, RSP_ACK};
            left_d  = 2'd2;
          end else begin
            state_d = ST_RD_EN;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

`ifndef PROGLOAD_READBACK_EN
  logic unused_dout;
  assign unused_dout = ^prog_dout;
`endif

  assign prog_addr = addr_q;
  assign prog_din  = din_q;
  assign sys_hold  = hold_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
